// File: rtl/usrt_pkg.sv
// Shared types and constants for the USRT serial transmit/receive path.
package usrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_t;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/usrt_baud_tick.sv
// Bit-period counter: counts 0..max(i_Div,1)-1 while enabled and strobes o_Bit_End on the last cycle.
module usrt_baud_tick #(
    parameter int DIV_W = 8
) (
    input  logic             i_Pclk,
    input  logic             i_Presetn,
    input  logic             i_Load,
    input  logic             i_En,
    input  logic [DIV_W-1:0] i_Div,
    output logic             o_Bit_End,
    output logic             o_End_Next
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] div_eff;

    assign div_eff   = (i_Div == '0) ? DIV_W'(1) : i_Div;
    assign o_Bit_End = i_En && (count == div_eff - DIV_W'(1));

    // Predicts o_Bit_End for the following cycle so the owner can register a strobe aligned to it.
    assign o_End_Next = (div_eff == DIV_W'(1)) ||
                        (!o_Bit_End && (count == div_eff - DIV_W'(2)));

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            count <= '0;
        end else if (i_Load) begin
            count <= '0;
        end else if (i_En) begin
            count <= o_Bit_End ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/txshift_frame.sv
// Serial transmit framer: start, DATA_W bits LSB first, optional parity, one or two stop bits.
// Parity support is compiled in only when TXSHIFT_PARITY_EN is defined.
module txshift_frame
    import usrt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              i_Pclk,
    input  logic              i_Presetn,
    input  logic [DIV_W-1:0]  i_Baud,
    input  logic              i_Stop2,
    input  logic              i_Parity_En,
    input  logic              i_Parity_Odd,
    input  logic              i_Valid,
    input  logic [DATA_W-1:0] i_Pwdata,
    output logic              o_Ready,
    output logic              o_Tx_Serial,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam int IDX_W = $clog2(DATA_W_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state, state_next;
    logic [DATA_W-1:0] shift_q, shift_next;
    logic [IDX_W-1:0]  bit_idx, bit_idx_next;
    logic [DIV_W-1:0]  baud_q;
    logic              stop2_q;
    logic              tx_q, tx_next;
    logic              busy_q;
    logic              done_q, done_next;
    logic              bit_end, end_next;
    logic              last_stop;
    logic              accept;

`ifdef TXSHIFT_PARITY_EN
    logic par_en_q;
    logic par_bit_q;

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= i_Parity_En;
            par_bit_q <= (^i_Pwdata) ^ i_Parity_Odd;
        end
    end
`else
    logic unused_parity_inputs;
    assign unused_parity_inputs = i_Parity_En ^ i_Parity_Odd;
`endif

    usrt_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .i_Pclk     (i_Pclk),
        .i_Presetn  (i_Presetn),
        .i_Load     (accept),
        .i_En       (state != IDLE),
        .i_Div      (baud_q),
        .o_Bit_End  (bit_end),
        .o_End_Next (end_next)
    );

    // Ready in IDLE and on the final cycle of the last stop bit, so frames can run back to back.
    assign last_stop = (state == STOP2) || ((state == STOP1) && !stop2_q);
    assign o_Ready   = (state == IDLE) || (last_stop && bit_end);
    assign accept    = i_Valid && o_Ready;

    always_comb begin
        state_next   = state;
        shift_next   = shift_q;
        bit_idx_next = bit_idx;
        case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_q >> 1;
                    if (bit_idx == LAST_IDX) begin
`ifdef TXSHIFT_PARITY_EN
                        state_next = par_en_q ? PARITY : STOP1;
`else
                        state_next = STOP1;
`endif
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef TXSHIFT_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP1;
            end
`endif
            STOP1: begin
                if (bit_end) begin
                    if (stop2_q)     state_next = STOP2;
                    else if (accept) state_next = START;
                    else             state_next = IDLE;
                end
            end
            STOP2: begin
                if (bit_end) state_next = accept ? START : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            shift_next   = i_Pwdata;
            bit_idx_next = '0;
        end
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        tx_next = IDLE_LEVEL;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef TXSHIFT_PARITY_EN
            PARITY:  tx_next = par_bit_q;
`endif
            default: tx_next = IDLE_LEVEL;
        endcase
        done_next = ((state_next == STOP2) || ((state_next == STOP1) && !stop2_q)) && end_next;
    end

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_idx <= '0;
            baud_q  <= '0;
            stop2_q <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            shift_q <= shift_next;
            bit_idx <= bit_idx_next;
            tx_q    <= tx_next;
            busy_q  <= (state_next != IDLE);
            done_q  <= done_next;
            if (accept) begin
                baud_q  <= i_Baud;
                stop2_q <= i_Stop2;
            end
        end
    end

    assign o_Tx_Serial = tx_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;

endmodule
